sprite_compositor: RTL and testbench

Parametrised pixel compositor for the VGA colour path. It holds NUM_SPRITES rectangular sprite slots, each with its own position, size, colour and enable. Per pixel, it resolves the highest-priority covering slot and drives 8-bit R/G/B into the VGA DAC stage. Slot updates are double-buffered and applied only at frame start, which prevents tearing. It also reports a per-frame sprite-overlap (collision) flag for game logic.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_hit.sv | 23 ++
 rtl/sprite_compositor.sv | 136 +++++++++++++
 tb/tb_sprite_compositor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite compositor: slot descriptor,
// pixel colour and the geometry defaults the slot struct is built on.
package sprite_pkg;

  localparam int COORD_W_DEF     = 10;
  localparam int NUM_SPRITES_DEF = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic                   en;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] w;
    logic [COORD_W_DEF-1:0] h;
    rgb_t                   color;
  } sprite_t;

  localparam rgb_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/sprite_hit.sv
// Combinational rectangle test for one sprite slot against the current pixel.
module sprite_hit
  import sprite_pkg::*;
(
  input  sprite_t                sprite,
  input  logic [COORD_W_DEF-1:0] px,
  input  logic [COORD_W_DEF-1:0] py,
  output logic                   hit
);

  logic [COORD_W_DEF:0] x_end;
  logic [COORD_W_DEF:0] y_end;

  // One extra bit keeps a sprite hanging off the right/bottom edge from
  // wrapping around to column/row 0.
  assign x_end = {1'b0, sprite.x} + {1'b0, sprite.w};
  assign y_end = {1'b0, sprite.y} + {1'b0, sprite.h};

  assign hit = sprite.en
            && (px >= sprite.x) && ({1'b0, px} < x_end)
            && (py >= sprite.y) && ({1'b0, py} < y_end);

endmodule

// File: rtl/sprite_compositor.sv
// Priority sprite compositor: double-buffered slot registers, two-stage pixel
// pipeline (hit vector, then priority/colour/overlap) and a per-frame collision flag.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int          COORD_W     = COORD_W_DEF,
  parameter int          IDX_W       = $clog2(NUM_SPRITES),
  parameter logic [23:0] BG_COLOR    = 24'h00FFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               display,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COORD_W-1:0] wr_w,
  input  logic [COORD_W-1:0] wr_h,
  input  logic [23:0]        wr_color,
  input  logic               wr_slot_en,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               collision
);

  localparam logic [IDX_W:0] SLOT_LIMIT = NUM_SPRITES[IDX_W:0];

  sprite_t shadow [NUM_SPRITES];
  sprite_t active [NUM_SPRITES];
  sprite_t wr_slot;
  logic    wr_in_range;

  assign wr_slot = '{en: wr_slot_en, x: wr_x, y: wr_y, w: wr_w, h: wr_h,
                     color: rgb_t'(wr_color)};
  assign wr_in_range = ({1'b0, wr_idx} < SLOT_LIMIT);

  // NOTE: the slot arrays are reset explicitly because "empty and disabled"
  // is the defined power-up content, not a don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en && wr_in_range) shadow[wr_idx] <= wr_slot;
      // NOTE: non-blocking assignment means active samples the shadow as it was
      // before a coincident write, so that write shows up one frame later.
      if (frame_start) active <= shadow;
    end
  end

  logic [NUM_SPRITES-1:0] hit_vec;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    sprite_hit u_hit (
      .sprite (active[i]),
      .px     (X),
      .py     (Y),
      .hit    (hit_vec[i])
    );
  end

  logic [NUM_SPRITES-1:0] hit_s1;
  logic                   disp_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_s1  <= '0;
      disp_s1 <= 1'b0;
    end else begin
      hit_s1  <= hit_vec;
      disp_s1 <= display;
    end
  end

  logic             win_any;
  logic [IDX_W-1:0] win_idx;
  logic             overlap;
  rgb_t             pix_color;

  // NOTE: every always_comb output gets a default before any branch so no
  // path can hold a stale value and infer a latch.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more slots hit.
  assign overlap = disp_s1 && ((hit_s1 & (hit_s1 - NUM_SPRITES'(1))) != '0);

  always_comb begin
    pix_color = BLACK;
    if (disp_s1) pix_color = win_any ? active[win_idx].color : rgb_t'(BG_COLOR);
  end

  logic sticky;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R     <= 8'h00;
      VGA_G     <= 8'h00;
      VGA_B     <= 8'h00;
      hit       <= 1'b0;
      hit_idx   <= '0;
      collision <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      VGA_R   <= pix_color.r;
      VGA_G   <= pix_color.g;
      VGA_B   <= pix_color.b;
      hit     <= disp_s1 && win_any;
      hit_idx <= (disp_s1 && win_any) ? win_idx : '0;
      if (frame_start) begin
        collision <= sticky || overlap;
        sticky    <= 1'b0;
      end else begin
        sticky <= sticky || overlap;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (6 slots, so out-of-range indices exist)
// with hand-computed expected colours, hit flags and collision state.
module tb_sprite_compositor;

  localparam int NS = 6;
  localparam int CW = 10;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          display = 1'b0;
  logic [CW-1:0] X = '0;
  logic [CW-1:0] Y = '0;
  logic          frame_start = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [CW-1:0] wr_x = '0;
  logic [CW-1:0] wr_y = '0;
  logic [CW-1:0] wr_w = '0;
  logic [CW-1:0] wr_h = '0;
  logic [23:0]   wr_color = '0;
  logic          wr_slot_en = 1'b0;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          collision;

  int compared = 0;
  int mismatched = 0;

  sprite_compositor #(
    .NUM_SPRITES (NS),
    .COORD_W     (CW),
    .IDX_W       (IW),
    .BG_COLOR    (24'h00FFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .display     (display),
    .X           (X),
    .Y           (Y),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_w        (wr_w),
    .wr_h        (wr_h),
    .wr_color    (wr_color),
    .wr_slot_en  (wr_slot_en),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input int w,
                            input int h, input int color, input bit en);
    wr_idx     = IW'(idx);
    wr_x       = CW'(x);
    wr_y       = CW'(y);
    wr_w       = CW'(w);
    wr_h       = CW'(h);
    wr_color   = 24'(color);
    wr_slot_en = en;
    wr_en      = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    display     = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Present one pixel and wait out the two-stage latency.
  task automatic pix(input int x, input int y, input bit disp);
    X       = CW'(x);
    Y       = CW'(y);
    display = disp;
    tick();
    tick();
  endtask

  task automatic check_px(input string tag, input int rgb, input bit exp_hit, input int exp_idx);
    check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(rgb));
    check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    check({tag, "_idx"}, 32'(hit_idx), 32'(exp_idx));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_px("reset", 24'h000000, 1'b0, 0);
    check("reset_coll", 32'(collision), 32'd0);
    #3 reset = 1'b0;

    // Background with no sprites
    pix(100, 100, 1'b1);
    check_px("bg", 24'h00FFFF, 1'b0, 0);
    check("bg_coll", 32'(collision), 32'd0);

    // Slot 3 rectangle edges
    write_slot(3, 10, 20, 4, 2, 24'hFF00FF, 1'b1);
    frame();
    for (int x = 9; x <= 14; x++) begin
      pix(x, 20, 1'b1);
      if (x >= 10 && x <= 13) check_px($sformatf("sweep_x%0d", x), 24'hFF00FF, 1'b1, 3);
      else check_px($sformatf("sweep_x%0d", x), 24'h00FFFF, 1'b0, 0);
    end
    pix(10, 21, 1'b1);
    check_px("row21", 24'hFF00FF, 1'b1, 3);
    pix(10, 22, 1'b1);
    check_px("row22", 24'h00FFFF, 1'b0, 0);
    pix(10, 20, 1'b0);
    check("blank_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);

    // Overlap of slots 1 and 5: priority and collision
    write_slot(1, 50, 50, 1, 1, 24'hFFFF00, 1'b1);
    write_slot(5, 48, 48, 5, 5, 24'h0000FF, 1'b1);
    frame();
    pix(50, 50, 1'b1);
    check_px("prio", 24'hFFFF00, 1'b1, 1);
    pix(48, 48, 1'b1);
    check_px("slot5", 24'h0000FF, 1'b1, 5);
    check("coll_before", 32'(collision), 32'd0);
    frame();
    check("coll_set", 32'(collision), 32'd1);
    tick();
    check("coll_hold", 32'(collision), 32'd1);
    frame();
    check("coll_clear", 32'(collision), 32'd0);

    // Double buffering of slot 0
    write_slot(0, 200, 200, 2, 2, 24'h112233, 1'b1);
    pix(200, 200, 1'b1);
    check_px("nofs", 24'h00FFFF, 1'b0, 0);
    wr_idx = 3'd0; wr_x = 10'd300; wr_y = 10'd300; wr_w = 10'd2; wr_h = 10'd2;
    wr_color = 24'h445566; wr_slot_en = 1'b1; wr_en = 1'b1;
    frame();
    wr_en = 1'b0;
    pix(200, 200, 1'b1);
    check_px("samecyc_old", 24'h112233, 1'b1, 0);
    pix(300, 300, 1'b1);
    check_px("samecyc_new", 24'h00FFFF, 1'b0, 0);
    frame();
    pix(300, 300, 1'b1);
    check_px("next_new", 24'h445566, 1'b1, 0);
    pix(200, 200, 1'b1);
    check_px("next_old", 24'h00FFFF, 1'b0, 0);

    // Right-edge sprite must not wrap
    write_slot(2, 1020, 0, 10, 5, 24'h0A0B0C, 1'b1);
    frame();
    pix(1023, 0, 1'b1);
    check_px("edge1023", 24'h0A0B0C, 1'b1, 2);
    pix(1019, 0, 1'b1);
    check_px("edge1019", 24'h00FFFF, 1'b0, 0);
    pix(0, 0, 1'b1);
    check_px("nowrap0", 24'h00FFFF, 1'b0, 0);
    pix(5, 0, 1'b1);
    check_px("nowrap5", 24'h00FFFF, 1'b0, 0);

    // Out-of-range slot indices are ignored
    write_slot(6, 0, 0, 8, 8, 24'h123456, 1'b1);
    write_slot(7, 0, 0, 8, 8, 24'h654321, 1'b1);
    frame();
    pix(2, 2, 1'b1);
    check_px("idx_oob", 24'h00FFFF, 1'b0, 0);
    pix(1023, 0, 1'b1);
    check_px("idx_oob_keep", 24'h0A0B0C, 1'b1, 2);

    // Reset mid-line: immediate black, then background only
    pix(10, 20, 1'b1);
    check_px("pre_rst", 24'hFF00FF, 1'b1, 3);
    #3 reset = 1'b1;
    #1;
    check_px("async_rst", 24'h000000, 1'b0, 0);
    tick();
    #3 reset = 1'b0;
    tick();
    check_px("post_rst1", 24'h000000, 1'b0, 0);
    tick();
    check_px("post_rst2", 24'h00FFFF, 1'b0, 0);
    check("post_rst_coll", 32'(collision), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
